// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: sequences a DDS tone generator through a list of FCW points.
// Resets the DDS, waits for its table-ready edge, then steps the FCW and
// forwards a fixed number of amplitude samples per point, tagged by index.
module dds_sweep_ctrl #(
    parameter int RST_CYCLES   = 2,
    parameter int LOAD_TIMEOUT = 8192,
    parameter int W_AMP        = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_fcw_start,
    input  logic [31:0]      cfg_fcw_step,
    input  logic [31:0]      cfg_offset,
    input  logic [15:0]      cfg_num_points,
    input  logic [15:0]      cfg_dwell,
    input  logic             dds_table_ready,
    input  logic [W_AMP-1:0] dds_amp,
    output logic             dds_rst_n,
    output logic [31:0]      dds_fcw,
    output logic [31:0]      dds_offset,
    output logic             samp_valid,
    output logic [W_AMP-1:0] samp_data,
    output logic [15:0]      samp_index,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int LT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(LOAD_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [RC_W-1:0] rst_cnt;
    logic [LT_W-1:0] load_cnt;
    logic            ready_q;
    logic [15:0]     pt_idx;
    logic [15:0]     dwell_cnt;
    // Shadow config; counts are stored as "last value" so 0 maps to 1 and
    // 65535 never needs a 17th bit.
    logic [31:0]     sh_step;
    logic [15:0]     np_last;
    logic [15:0]     dw_last;

    // Sequencer FSM with all outputs registered; abort overrides at the end.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            load_cnt    <= '0;
            ready_q     <= 1'b0;
            pt_idx      <= '0;
            dwell_cnt   <= '0;
            sh_step     <= '0;
            np_last     <= '0;
            dw_last     <= '0;
            dds_rst_n   <= 1'b0;
            dds_fcw     <= '0;
            dds_offset  <= '0;
            samp_valid  <= 1'b0;
            samp_data   <= '0;
            samp_index  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            samp_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    dds_rst_n <= 1'b0;
                    ready_q   <= 1'b0;
                    if (start) begin
                        sh_step     <= cfg_fcw_step;
                        np_last     <= (cfg_num_points == 16'd0) ? 16'd0 : cfg_num_points - 16'd1;
                        dw_last     <= (cfg_dwell == 16'd0) ? 16'd0 : cfg_dwell - 16'd1;
                        dds_fcw     <= cfg_fcw_start;
                        dds_offset  <= cfg_offset;
                        timeout_err <= 1'b0;
                        rst_cnt     <= '0;
                        busy        <= 1'b1;
                        state       <= S_INIT;
                    end
                end
                S_INIT: begin
                    // Track the flag while the DDS is in reset so a level
                    // already high on entry to LOAD is not seen as an edge.
                    ready_q <= dds_table_ready;
                    if (rst_cnt == RC_LAST) begin
                        dds_rst_n <= 1'b1;
                        load_cnt  <= '0;
                        state     <= S_LOAD;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                S_LOAD: begin
                    ready_q <= dds_table_ready;
                    if (dds_table_ready && !ready_q) begin
                        pt_idx    <= '0;
                        dwell_cnt <= '0;
                        state     <= S_RUN;
                    end else if (load_cnt == LT_LAST) begin
                        timeout_err <= 1'b1;
                        dds_rst_n   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        load_cnt <= load_cnt + LT_W'(1);
                    end
                end
                S_RUN: begin
                    samp_valid <= 1'b1;
                    samp_data  <= dds_amp;
                    samp_index <= pt_idx;
                    if (dwell_cnt == dw_last) begin
                        if (pt_idx == np_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            dwell_cnt <= '0;
                            pt_idx    <= pt_idx + 16'd1;
                            dds_fcw   <= dds_fcw + sh_step;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    dds_rst_n <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    dds_rst_n <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
            // Abort wins over every other transition: no done, no error,
            // and the sample that would have followed is dropped.
            if (abort && state != S_IDLE) begin
                state       <= S_IDLE;
                dds_rst_n   <= 1'b0;
                busy        <= 1'b0;
                samp_valid  <= 1'b0;
                done        <= 1'b0;
                timeout_err <= timeout_err;
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with hand-computed expectations.
module tb_dds_sweep_ctrl;

    localparam int W_AMP = 16;

    logic             sys_clk = 1'b0;
    logic             reset;
    logic             start, abort;
    logic [31:0]      cfg_fcw_start, cfg_fcw_step, cfg_offset;
    logic [15:0]      cfg_num_points, cfg_dwell;
    logic             dds_table_ready;
    logic [W_AMP-1:0] dds_amp;
    logic             dds_rst_n;
    logic [31:0]      dds_fcw, dds_offset;
    logic             samp_valid;
    logic [W_AMP-1:0] samp_data;
    logic [15:0]      samp_index;
    logic             busy, done, timeout_err;

    int vectors = 0;
    int miscompares = 0;

    dds_sweep_ctrl #(.RST_CYCLES(2), .LOAD_TIMEOUT(16), .W_AMP(W_AMP)) dut (
        .sys_clk(sys_clk), .reset(reset), .start(start), .abort(abort),
        .cfg_fcw_start(cfg_fcw_start), .cfg_fcw_step(cfg_fcw_step),
        .cfg_offset(cfg_offset), .cfg_num_points(cfg_num_points),
        .cfg_dwell(cfg_dwell), .dds_table_ready(dds_table_ready),
        .dds_amp(dds_amp), .dds_rst_n(dds_rst_n), .dds_fcw(dds_fcw),
        .dds_offset(dds_offset), .samp_valid(samp_valid),
        .samp_data(samp_data), .samp_index(samp_index), .busy(busy),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Accept a start, scramble cfg inputs, pass INIT, pulse table_ready.
    // Returns with the block in RUN and no sample emitted yet.
    task automatic begin_sweep(input logic [31:0] fs, input logic [31:0] st,
                               input logic [15:0] np, input logic [15:0] dw);
        cfg_fcw_start = fs; cfg_fcw_step = st; cfg_num_points = np; cfg_dwell = dw;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_fcw_start = 32'h5555_AAAA; cfg_fcw_step = 32'h0F0F_0F0F;
        cfg_num_points = 16'd9; cfg_dwell = 16'd9;
        tick();
        tick();
        dds_table_ready = 1'b1;
        tick();
        dds_table_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; dds_table_ready = 1'b0;
        dds_amp = 16'h0; cfg_fcw_start = '0; cfg_fcw_step = '0; cfg_offset = '0;
        cfg_num_points = '0; cfg_dwell = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_dds_rst_n", dds_rst_n, 0);
        chk("rst_fcw", dds_fcw, 0);
        chk("rst_valid", samp_valid, 0);
        chk("rst_terr", timeout_err, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // ---- basic sweep: 3 points x 4 dwell ----
        cfg_fcw_start = 32'h0111_1111; cfg_fcw_step = 32'h0010_0000;
        cfg_offset = 32'h00AB_CDEF; cfg_num_points = 16'd3; cfg_dwell = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_fcw_start = 32'hDEAD_BEEF; cfg_fcw_step = 32'h0; cfg_offset = 32'h0;
        cfg_num_points = 16'd7; cfg_dwell = 16'd9;
        chk("acc_busy", busy, 1);
        chk("acc_fcw", dds_fcw, 32'h0111_1111);
        chk("acc_offset", dds_offset, 32'h00AB_CDEF);
        chk("init_rst_n0", dds_rst_n, 0);
        tick();
        chk("init_rst_n1", dds_rst_n, 0);
        tick();
        chk("load_rst_n", dds_rst_n, 1);
        repeat (7) tick();
        chk("load_no_valid", samp_valid, 0);
        dds_table_ready = 1'b1;
        tick();
        dds_table_ready = 1'b0;
        chk("run_entry_valid", samp_valid, 0);
        for (int k = 0; k < 12; k++) begin
            dds_amp = 16'h1000 + 16'(k * 16'h0111);
            tick();
            chk("bs_valid", samp_valid, 1);
            chk("bs_index", samp_index, 32'(k / 4));
            chk("bs_data", samp_data, 32'(16'h1000 + 16'(k * 16'h0111)));
            chk("bs_fcw", dds_fcw, (k < 3) ? 32'h0111_1111 : (k < 7) ? 32'h0121_1111 : 32'h0131_1111);
            chk("bs_done", done, (k == 11) ? 1 : 0);
            chk("bs_busy", busy, 1);
        end
        dds_amp = 16'hBEEF;
        tick();
        chk("bs_end_valid", samp_valid, 0);
        chk("bs_end_done", done, 0);
        chk("bs_end_busy", busy, 0);
        chk("bs_end_fcw", dds_fcw, 32'h0131_1111);
        chk("bs_end_rst_n", dds_rst_n, 0);

        // ---- wrap with dwell=0 ----
        begin_sweep(32'hFFFF_FFF0, 32'h0000_0020, 16'd2, 16'd0);
        chk("wr_fcw0", dds_fcw, 32'hFFFF_FFF0);
        tick();
        chk("wr_v0", samp_valid, 1);
        chk("wr_i0", samp_index, 0);
        chk("wr_fcw1", dds_fcw, 32'h0000_0010);
        chk("wr_d0", done, 0);
        tick();
        chk("wr_v1", samp_valid, 1);
        chk("wr_i1", samp_index, 1);
        chk("wr_d1", done, 1);
        tick();
        chk("wr_end", samp_valid, 0);

        // ---- points=0, dwell=0 -> one sample ----
        begin_sweep(32'h0000_1000, 32'h0000_0100, 16'd0, 16'd0);
        tick();
        chk("z_v0", samp_valid, 1);
        chk("z_done", done, 1);
        tick();
        chk("z_end_v", samp_valid, 0);
        chk("z_end_busy", busy, 0);
        chk("z_fcw", dds_fcw, 32'h0000_1000);

        // ---- timeout after 16 LOAD cycles ----
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("to_load", dds_rst_n, 1);
        repeat (15) tick();
        chk("to_busy15", busy, 1);
        chk("to_terr15", timeout_err, 0);
        tick();
        chk("to_busy16", busy, 0);
        chk("to_terr16", timeout_err, 1);
        chk("to_rst_n", dds_rst_n, 0);
        chk("to_valid", samp_valid, 0);
        tick();
        chk("to_sticky", timeout_err, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_clear", timeout_err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_init", busy, 0);

        // ---- level held through INIT is not an edge ----
        cfg_num_points = 16'd1; cfg_dwell = 16'd1;
        dds_table_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        repeat (3) tick();
        chk("lvl_busy", busy, 1);
        chk("lvl_novalid", samp_valid, 0);
        dds_table_ready = 1'b0;
        tick();
        dds_table_ready = 1'b1;
        tick();
        chk("lvl_run_entry", samp_valid, 0);
        tick();
        chk("lvl_valid", samp_valid, 1);
        chk("lvl_done", done, 1);
        dds_table_ready = 1'b0;
        tick();
        chk("lvl_idle", busy, 0);

        // ---- abort mid-RUN with start held ----
        begin_sweep(32'h0111_1111, 32'h0010_0000, 16'd3, 16'd4);
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ab_valid", samp_valid, 1);
            chk("ab_index", samp_index, 0);
            chk("ab_busy", busy, 1);
        end
        chk("ab_fcw", dds_fcw, 32'h0121_1111);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid_sup", samp_valid, 0);
        chk("ab_busy_off", busy, 0);
        chk("ab_no_done", done, 0);
        chk("ab_no_err", timeout_err, 0);
        repeat (3) tick();
        chk("ab_quiet", samp_valid, 0);

        // ---- start and abort together in IDLE: start wins ----
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0;
        chk("sa_busy", busy, 1);
        tick();
        abort = 1'b0;
        chk("sa_abort", busy, 0);

        // ---- async reset mid-RUN ----
        dds_amp = 16'h7777;
        begin_sweep(32'h0111_1111, 32'h0010_0000, 16'd3, 16'd4);
        tick(); tick();
        chk("ar_valid", samp_valid, 1);
        #3 reset = 1'b1;
        #1;
        chk("ar_valid0", samp_valid, 0);
        chk("ar_busy0", busy, 0);
        chk("ar_fcw0", dds_fcw, 0);
        chk("ar_rst_n0", dds_rst_n, 0);
        chk("ar_data0", samp_data, 0);
        chk("ar_idx0", samp_index, 0);
        #2 reset = 1'b0;
        tick(); tick();
        chk("ar_idle_busy", busy, 0);
        chk("ar_idle_rst_n", dds_rst_n, 0);
        chk("ar_idle_valid", samp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
